truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Self-checking exhaustive stimulus engine for combinational experiments. On `start` it drives every input combination of an N-input function, from all-zeros up to all-ones, holding each combination for a programmable dwell. After each dwell it compares a reference implementation output against a candidate output. It counts mismatches, records the first failing vector and reports pass or fail. It sits between the lab harness and the two implementations under test, and replaces hand-written per-vector stimulus sequences.

## Interface
Parameters:
- `N_INPUTS`, default 3: number of function inputs. Legal range 1–16.
- `DWELL`, default 2: cycles each vector is held. Legal range 1–255. The comparison happens on the last cycle of the dwell.

Ports:
- `clk`  in  1  sole clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep. Sampled only in IDLE or DONE.
- `y_ref`  in  1  reference implementation output (for example, the two-level form).
- `y_dut`  in  1  candidate implementation output (for example, the three-level form).
- `vector`  out  N_INPUTS  current input combination; bit N_INPUTS-1 is the MSB (the "A" input).
- `busy`  out  1  high while sweeping.
- `done`  out  1  high from sweep completion until the next `start` or `reset`.
- `pass`  out  1  valid when `done`=1; 1 iff `mismatch_count`==0.
- `mismatch_count`  out  N_INPUTS+1  number of mismatching vectors in the last sweep.
- `first_fail_valid`  out  1  at least one mismatch has been seen this sweep.
- `first_fail_vec`  out  N_INPUTS  lowest vector that mismatched.

## Operation
- Reset values: state IDLE; `vector`=0; `busy`=0; `done`=0; `pass`=0; `mismatch_count`=0; `first_fail_valid`=0; `first_fail_vec`=0; dwell counter 0.
- State machine:
  - IDLE, `start`=1: go to DRIVE. Set `vector`=0, dwell counter=0, and clear the count and first-fail fields.
  - DRIVE, dwell counter < DWELL-1: increment the dwell counter.
  - DRIVE, dwell counter == DWELL-1: compare the inputs.
    - Mismatch (`y_ref`≠`y_dut`): increment `mismatch_count`. If `first_fail_valid`=0, set `first_fail_vec`=`vector` and `first_fail_valid`=1.
    - Then, if `vector` is all-ones, go to DONE. Otherwise increment `vector` and reset the dwell counter to 0.
  - DONE: `done`=1 and `busy`=0. `vector` holds all-ones. `start`=1 restarts exactly as from IDLE and drops `done` on the next edge.
- `start` while in DRIVE is ignored.
- Width rules:
  - `vector` never wraps; the terminal test is all-ones.
  - `mismatch_count` is N_INPUTS+1 bits, so a count of 2^N_INPUTS is representable and the counter never saturates.
  - `pass` is a registered function of the count and is updated on entry to DONE.
- `busy`=1 exactly while in DRIVE.
- `y_ref` and `y_dut` are sampled only on compare cycles. X on these inputs outside compare cycles has no effect.
- Reset mid-sweep: all outputs return to their reset values on the next edge, and no partial result is retained.
- Reset has priority over `start` on the same edge.

## Timing
- `start` is sampled high at edge k. Vector v is driven during cycles k+1+v·DWELL through k+(v+1)·DWELL.
- Vector v is compared at the edge ending cycle k+(v+1)·DWELL.
- `done` rises at cycle k+1+2^N·DWELL. For the defaults, that is 17 cycles after the start edge.
- DWELL=1: every DRIVE cycle is a compare cycle, and a new vector appears every cycle.
- The DUT path is purely combinational from `vector` to `y_*`. With DWELL≥1, `y_*` must settle within one cycle.
- Back-to-back sweeps: `start` held high through DONE starts the next sweep one cycle after DONE is entered.

## Structure
- Package `truth_table_pkg` contains:
  - the state enum (IDLE, DRIVE, DONE);
  - the function `sweep_cycles(n, dwell)`, which returns 2^n·dwell for benches;
  - localparam limits MAX_INPUTS=16 and MAX_DWELL=255.
- One sub-module, `dwell_counter`: a DWELL-parametrised counter with `clr` and `en` inputs and a `last` output. It is also reused by future multi-output sweepers.
- Everything else lives in the top level.

## Test plan
- Defaults (N=3, DWELL=2): `y_ref` and `y_dut` driven by equivalent functions, then `start` -> `done` 17 cycles later, `pass`=1, `mismatch_count`=0, `first_fail_valid`=0.
- `y_dut` differs from `y_ref` only at vectors 3'b101 and 3'b110 -> `mismatch_count`=2, `first_fail_vec`=3'b101, `pass`=0.
- N=2, DWELL=1, `y_dut`=~`y_ref` -> `vector` steps 0,1,2,3 on consecutive cycles; `mismatch_count`=4 (3'b100, no overflow); `done` rises 5 cycles after the start edge.
- `reset` asserted while `vector`=3'b011 mid-sweep -> next cycle all outputs are 0 and the state is IDLE. A new `start` then gives a clean 17-cycle sweep with a fresh count.
- `start` pulsed during DRIVE -> ignored, and sweep length is unchanged. `start` held through DONE -> second sweep begins, `done` deasserts one edge later, and counters clear.
- X driven on `y_dut` during non-compare cycles, correct values on compare cycles -> `pass`=1.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and limits for the truth-table sweeper family.
package truth_table_pkg;

  localparam int MAX_INPUTS = 16;
  localparam int MAX_DWELL  = 255;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  // Number of DRIVE cycles in one full sweep.
  function automatic int unsigned sweep_cycles(input int unsigned n, input int unsigned dwell);
    return (32'd1 << n) * dwell;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_dwell_counter.sv
// Per-vector dwell timer: counts 0..DWELL-1 while enabled and flags the final cycle.
module dwell_counter #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [W-1:0] TERM = W'(DWELL - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

  // With DWELL=1 the count never leaves zero, so every cycle is a compare cycle.
  assign last = (count == TERM);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input combination, compares reference
// and candidate outputs at the end of each dwell, and summarises the result.
module truth_table_sweeper #(
  parameter int N_INPUTS = 3,
  parameter int DWELL    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                y_ref,
  input  logic                y_dut,
  output logic [N_INPUTS-1:0] vector,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   mismatch_count,
  output logic                first_fail_valid,
  output logic [N_INPUTS-1:0] first_fail_vec
);
  import truth_table_pkg::*;

  state_t            state;
  logic              last;
  logic              mismatch;
  logic              all_ones;
  logic [N_INPUTS:0] count_nxt;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (state != DRIVE),
    .en    (state == DRIVE),
    .last  (last)
  );

  // Only consumed on compare cycles, so y_* are don't-care elsewhere.
  assign mismatch  = y_ref ^ y_dut;
  assign count_nxt = mismatch_count + (N_INPUTS+1)'(mismatch);
  assign all_ones  = &vector;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      vector           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= DRIVE;
            vector           <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        DRIVE: begin
          if (last) begin
            mismatch_count <= count_nxt;
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vector;
            end
            if (all_ones) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (count_nxt == '0);
            end else begin
              vector <= vector + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: random truth tables scored against a popcount/lowest-bit model.
module tb_truth_table_sweeper;
  import truth_table_pkg::*;

  localparam int D1 = 2;

  logic       clk = 1'b0;
  logic       reset, start, start2;
  logic [7:0] ref_tt, dut_tt;
  logic [3:0] r2_tt;
  logic       garb;
  int         vecs = 0;
  int         errs = 0;

  logic       y_ref, y_dut, busy, done, pass, ffv;
  logic [2:0] vector, ffvec;
  logic [3:0] mcount;

  logic       y_ref2, y_dut2, busy2, done2, pass2, ffv2;
  logic [1:0] vector2, ffvec2;
  logic [2:0] mcount2;

  always #5 clk = ~clk;

  assign y_ref  = ref_tt[vector];
  assign y_dut  = garb ? ~dut_tt[vector] : dut_tt[vector];
  assign y_ref2 = r2_tt[vector2];
  assign y_dut2 = ~y_ref2;

  truth_table_sweeper #(.N_INPUTS(3), .DWELL(D1)) dut (
    .clk(clk), .reset(reset), .start(start), .y_ref(y_ref), .y_dut(y_dut),
    .vector(vector), .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mcount), .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );

  truth_table_sweeper #(.N_INPUTS(2), .DWELL(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .y_ref(y_ref2), .y_dut(y_dut2),
    .vector(vector2), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch_count(mcount2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input logic [7:0] rt, input logic [7:0] dt,
                           input bit garb_en, input bit pulse_mid, input bit restart);
    int         exp_cnt;
    bit         exp_ffv;
    logic [2:0] exp_ff;
    int         t;
    ref_tt  = rt;
    dut_tt  = dt;
    exp_cnt = 0;
    exp_ffv = 0;
    exp_ff  = '0;
    for (int v = 7; v >= 0; v--) begin
      if (rt[v] !== dt[v]) begin
        exp_cnt++;
        exp_ffv = 1;
        exp_ff  = 3'(v);
      end
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s < (restart ? 2 : 1); s++) begin
      for (t = 1; t <= 40; t++) begin
        garb = garb_en && (t % D1 == 1);
        if (pulse_mid) start = (t == 5);
        if (done) break;
        check("sweep_vector", 32'(vector), 32'((t - 1) / D1));
        check("sweep_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
      end
      garb  = 1'b0;
      start = 1'b0;
      check("sweep_length", 32'(t), sweep_cycles(3, D1) + 1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_vector", 32'(vector), 32'd7);
      check("mismatch_count", 32'(mcount), 32'(exp_cnt));
      check("pass", 32'(pass), 32'(exp_cnt == 0));
      check("first_fail_valid", 32'(ffv), 32'(exp_ffv));
      check("first_fail_vec", 32'(ffvec), 32'(exp_ff));
      if (restart && s == 0) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_done", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_vector", 32'(vector), 32'd0);
        check("restart_count", 32'(mcount), 32'd0);
        check("restart_ffv", 32'(ffv), 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] rt;
    int         t;
    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    garb   = 1'b0;
    ref_tt = '0;
    dut_tt = '0;
    r2_tt  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vector", 32'(vector), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_count", 32'(mcount), 32'd0);
    check("rst_ffv", 32'(ffv), 32'd0);
    check("rst_ffvec", 32'(ffvec), 32'd0);
    check("rst2_done", 32'(done2), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    rt = 8'($urandom);
    run_sweep(rt, rt, 0, 0, 0);
    run_sweep(rt, rt ^ 8'h60, 0, 0, 0);
    run_sweep(8'($urandom), 8'($urandom), 0, 1, 0);
    run_sweep(8'($urandom), 8'($urandom), 0, 0, 1);
    rt = 8'($urandom);
    run_sweep(rt, rt, 1, 0, 0);

    // Narrow, single-cycle-dwell instance with an always-wrong candidate.
    r2_tt = 4'($urandom);
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (t = 1; t <= 20; t++) begin
      if (done2) break;
      check("n2_vector", 32'(vector2), 32'(t - 1));
      check("n2_busy", 32'(busy2), 32'd1);
      @(posedge clk); #1;
    end
    check("n2_length", 32'(t), sweep_cycles(2, 1) + 1);
    check("n2_count", 32'(mcount2), 32'd4);
    check("n2_pass", 32'(pass2), 32'd0);
    check("n2_ffv", 32'(ffv2), 32'd1);
    check("n2_ffvec", 32'(ffvec2), 32'd0);

    // Abort a failing sweep at vector 3, then confirm a clean sweep starts fresh.
    rt     = 8'($urandom);
    ref_tt = rt;
    dut_tt = ~rt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (t = 0; t < 40; t++) begin
      if (vector == 3'd3) break;
      @(posedge clk); #1;
    end
    check("abort_reached_vec3", 32'(vector), 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_vector", 32'(vector), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_count", 32'(mcount), 32'd0);
    check("abort_ffv", 32'(ffv), 32'd0);
    check("abort_ffvec", 32'(ffvec), 32'd0);
    run_sweep(rt, rt, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
